// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory controller.
//   IMEM_ADDR_W : default word-address width of the instruction memory
//   IMEM_DATA_W : default instruction word width
//   state_t     : controller FSM state encoding (IDLE / LOAD / DONE)
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/imem_load_counter.sv
// Loader burst bookkeeping: write pointer PTR and remaining-word counter REM.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   i_load     : capture i_base into PTR and the clamped i_count into REM
//   i_base     : burst start address
//   i_count    : requested burst length in words
//   i_step     : one word accepted; PTR advances (wrapping), REM decrements
//   o_ptr      : current write address
//   o_last     : REM == 1, i.e. the next accepted word ends the burst
module imem_load_counter
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
)
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_count,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_last
);

    // A burst can never usefully exceed the whole memory.
    localparam logic [ADDR_W:0] REM_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_rem;
    logic [ADDR_W:0]   w_count_clamped;

    assign w_count_clamped = (i_count > REM_MAX) ? REM_MAX : i_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr <= '0;
            r_rem <= '0;
        end else if (i_load) begin
            r_ptr <= i_base;
            r_rem <= w_count_clamped;
        end else if (i_step) begin
            // Natural overflow of the ADDR_W-bit pointer gives the wrap to 0.
            r_ptr <= r_ptr + ADDR_W'(1);
            r_rem <= r_rem - (ADDR_W+1)'(1);
        end
    end

    assign o_ptr  = r_ptr;
    assign o_last = (r_rem == (ADDR_W+1)'(1));

endmodule

// File: rtl/imem_controller.sv
// Instruction-memory controller arbitrating a fetch read port and a burst
// loader onto a single memory port with combinational read data.
// Ports:
//   CLK, RST_N         : clock, asynchronous active-low reset
//   F_REQ, F_ADDR      : fetch request and word address
//   F_GNT              : fetch accepted this cycle (IDLE only)
//   F_DATA, F_VALID    : registered fetch word, valid the cycle after grant
//   L_START            : one-cycle burst start (honoured in IDLE only)
//   L_BASE, L_COUNT    : burst start address and length in words
//   L_VALID, L_DATA    : loader word handshake and payload
//   L_READY, L_BUSY    : burst in progress, words are being accepted
//   L_DONE             : one-cycle burst-complete pulse
//   MEM_WE, MEM_ADDR, MEM_DATA, MEM_Q : memory port
module imem_controller
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
)
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              F_REQ,
    input  logic [ADDR_W-1:0] F_ADDR,
    output logic              F_GNT,
    output logic [DATA_W-1:0] F_DATA,
    output logic              F_VALID,
    input  logic              L_START,
    input  logic [ADDR_W-1:0] L_BASE,
    input  logic [ADDR_W:0]   L_COUNT,
    input  logic              L_VALID,
    input  logic [DATA_W-1:0] L_DATA,
    output logic              L_READY,
    output logic              L_BUSY,
    output logic              L_DONE,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA,
    input  logic [DATA_W-1:0] MEM_Q
);

    state_t            r_state;
    logic [DATA_W-1:0] r_fdata;
    logic              r_fvalid;

    logic              w_in_idle;
    logic              w_in_load;
    logic              w_in_done;
    logic              w_gnt;
    logic              w_count_zero;
    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic [ADDR_W-1:0] w_ptr;

    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_in_load    = (r_state == ST_LOAD);
    assign w_in_done    = (r_state == ST_DONE);
    assign w_gnt        = w_in_idle & F_REQ;
    assign w_count_zero = (L_COUNT == '0);
    assign w_load       = w_in_idle & L_START & ~w_count_zero;
    assign w_step       = w_in_load & L_VALID;

    imem_load_counter #(
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_load  (w_load),
        .i_base  (L_BASE),
        .i_count (L_COUNT),
        .i_step  (w_step),
        .o_ptr   (w_ptr),
        .o_last  (w_last)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_fdata  <= '0;
            r_fvalid <= 1'b0;
        end else begin
            // Fetch data is captured only on a grant, so F_DATA holds otherwise.
            r_fvalid <= w_gnt;
            if (w_gnt) begin
                r_fdata <= MEM_Q;
            end
            case (r_state)
                ST_IDLE: begin
                    // A concurrent fetch is granted this cycle; the burst
                    // takes the port from the next cycle on.
                    if (L_START) begin
                        r_state <= w_count_zero ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (L_VALID && w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign F_GNT    = w_gnt;
    assign F_DATA   = r_fdata;
    assign F_VALID  = r_fvalid;
    assign L_READY  = w_in_load;
    assign L_BUSY   = w_in_load;
    assign L_DONE   = w_in_done;
    assign MEM_WE   = w_step;
    assign MEM_ADDR = w_in_load ? w_ptr : F_ADDR;
    assign MEM_DATA = L_DATA;

endmodule

// File: tb/tb_imem_controller.sv
module tb_imem_controller;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          CLK;
    logic          RST_N;
    logic          F_REQ;
    logic [AW-1:0] F_ADDR;
    logic          F_GNT;
    logic [DW-1:0] F_DATA;
    logic          F_VALID;
    logic          L_START;
    logic [AW-1:0] L_BASE;
    logic [AW:0]   L_COUNT;
    logic          L_VALID;
    logic [DW-1:0] L_DATA;
    logic          L_READY;
    logic          L_BUSY;
    logic          L_DONE;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DATA;
    logic [DW-1:0] MEM_Q;

    imem_controller #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .F_REQ    (F_REQ),
        .F_ADDR   (F_ADDR),
        .F_GNT    (F_GNT),
        .F_DATA   (F_DATA),
        .F_VALID  (F_VALID),
        .L_START  (L_START),
        .L_BASE   (L_BASE),
        .L_COUNT  (L_COUNT),
        .L_VALID  (L_VALID),
        .L_DATA   (L_DATA),
        .L_READY  (L_READY),
        .L_BUSY   (L_BUSY),
        .L_DONE   (L_DONE),
        .MEM_WE   (MEM_WE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_DATA (MEM_DATA),
        .MEM_Q    (MEM_Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Write/done monitor, sampled on the falling edge.
    int            cyc = 0;
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    int            q_cyc[$];
    int            done_n   = 0;
    int            done_cyc = -1;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (MEM_WE === 1'b1) begin
            q_addr.push_back(MEM_ADDR);
            q_data.push_back(MEM_DATA);
            q_cyc.push_back(cyc);
        end
        if (L_DONE === 1'b1) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        done_n   = 0;
        done_cyc = -1;
    endtask

    // Runs one burst from IDLE; the loader inserts 'gap' idle cycles before
    // every word after the first. Called at posedge+1.
    task automatic run_burst(input logic [AW-1:0] base, input logic [AW:0] cnt,
                             input int gap, input int budget, output int start_cyc);
        int k;
        int g;
        int n;
        clear_log();
        L_BASE    = base;
        L_COUNT   = cnt;
        L_VALID   = 1'b0;
        L_START   = 1'b1;
        start_cyc = cyc;
        @(posedge CLK); #1;
        L_START = 1'b0;
        k = 0;
        g = gap;
        n = 0;
        while (n < budget && L_BUSY === 1'b1) begin
            if (g < gap) begin
                L_VALID = 1'b0;
                g++;
            end else begin
                L_VALID = 1'b1;
                L_DATA  = 32'hAB00_0000 + k;
                k++;
                g = 0;
            end
            @(posedge CLK); #1;
            n++;
        end
        L_VALID = 1'b0;
        chk("burst_finished", {63'd0, L_BUSY}, 64'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
    endtask

    typedef struct {
        logic          f_req;
        logic [AW-1:0] f_addr;
        logic [DW-1:0] mem_q;
        logic          exp_gnt;
        logic          exp_vld;
        logic [DW-1:0] exp_data;
    } fvec_t;

    fvec_t tbl[5];
    int    s;

    initial begin
        // F_DATA holds when not granted (entries 1 and 4).
        tbl[0] = '{1'b1, 10'd5,    32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF};
        tbl[1] = '{1'b0, 10'd7,    32'h1234_5678, 1'b0, 1'b0, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 10'd1023, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000};
        tbl[3] = '{1'b1, 10'd0,    32'hA5A5_A5A5, 1'b1, 1'b1, 32'hA5A5_A5A5};
        tbl[4] = '{1'b0, 10'd3,    32'hFFFF_FFFF, 1'b0, 1'b0, 32'hA5A5_A5A5};

        RST_N   = 1'b0;
        F_REQ   = 1'b0;
        F_ADDR  = '0;
        L_START = 1'b0;
        L_BASE  = '0;
        L_COUNT = '0;
        L_VALID = 1'b0;
        L_DATA  = '0;
        MEM_Q   = 32'h1111_1111;

        // Reset state
        #3;
        chk("rst_f_valid", {63'd0, F_VALID}, 64'd0);
        chk("rst_f_data",  {32'd0, F_DATA}, 64'd0);
        chk("rst_l_busy",  {63'd0, L_BUSY}, 64'd0);
        chk("rst_l_ready", {63'd0, L_READY}, 64'd0);
        chk("rst_l_done",  {63'd0, L_DONE}, 64'd0);
        chk("rst_mem_we",  {63'd0, MEM_WE}, 64'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Fetch vectors
        for (int i = 0; i < 5; i++) begin
            F_REQ  = tbl[i].f_req;
            F_ADDR = tbl[i].f_addr;
            MEM_Q  = tbl[i].mem_q;
            @(negedge CLK);
            chk($sformatf("f_gnt[%0d]", i), {63'd0, F_GNT}, {63'd0, tbl[i].exp_gnt});
            chk($sformatf("mem_addr[%0d]", i), {54'd0, MEM_ADDR}, {54'd0, tbl[i].f_addr});
            chk($sformatf("mem_we[%0d]", i), {63'd0, MEM_WE}, 64'd0);
            @(posedge CLK); #1;
            chk($sformatf("f_valid[%0d]", i), {63'd0, F_VALID}, {63'd0, tbl[i].exp_vld});
            chk($sformatf("f_data[%0d]", i), {32'd0, F_DATA}, {32'd0, tbl[i].exp_data});
        end
        F_REQ = 1'b0;

        // Continuous burst of 3 from address 10
        run_burst(10'd10, 11'd3, 0, 20, s);
        chk("b3_nwr", q_addr.size(), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b3_addr[%0d]", i), {54'd0, q_addr[i]}, 64'd10 + i);
            chk($sformatf("b3_data[%0d]", i), {32'd0, q_data[i]}, 64'hAB00_0000 + i);
            chk($sformatf("b3_cyc[%0d]", i), q_cyc[i], s + 1 + i);
        end
        chk("b3_done_n", done_n, 64'd1);
        chk("b3_done_cyc", done_cyc, s + 4);
        F_REQ  = 1'b1;
        F_ADDR = 10'd9;
        @(negedge CLK);
        chk("b3_fetch_after", {63'd0, F_GNT}, 64'd1);
        @(posedge CLK); #1;
        F_REQ = 1'b0;

        // Wrap with stalls: 1023 then 0, two idle cycles between
        run_burst(10'd1023, 11'd2, 2, 20, s);
        chk("wr_nwr", q_addr.size(), 64'd2);
        chk("wr_addr0", {54'd0, q_addr[0]}, 64'd1023);
        chk("wr_addr1", {54'd0, q_addr[1]}, 64'd0);
        chk("wr_data1", {32'd0, q_data[1]}, 64'hAB00_0001);
        chk("wr_gap", q_cyc[1] - q_cyc[0], 64'd3);
        chk("wr_done_n", done_n, 64'd1);
        chk("wr_done_cyc", done_cyc, q_cyc[1] + 1);

        // Zero-length burst
        run_burst(10'd40, 11'd0, 0, 5, s);
        chk("z_nwr", q_addr.size(), 64'd0);
        chk("z_done_n", done_n, 64'd1);
        chk("z_done_cyc", done_cyc, s + 1);

        // Oversized burst clamps to the memory size
        run_burst(10'd100, 11'd2000, 0, 1100, s);
        chk("big_nwr", q_addr.size(), 64'd1024);
        chk("big_first", {54'd0, q_addr[0]}, 64'd100);
        chk("big_wrap", {54'd0, q_addr[924]}, 64'd0);
        chk("big_last", {54'd0, q_addr[1023]}, 64'd99);
        chk("big_done_n", done_n, 64'd1);

        // Fetch and start in the same cycle
        clear_log();
        F_REQ   = 1'b1;
        F_ADDR  = 10'd7;
        MEM_Q   = 32'h5555_AAAA;
        L_START = 1'b1;
        L_BASE  = 10'd200;
        L_COUNT = 11'd1;
        L_VALID = 1'b1;
        L_DATA  = 32'h0000_0077;
        @(negedge CLK);
        chk("ct_gnt", {63'd0, F_GNT}, 64'd1);
        chk("ct_we_idle", {63'd0, MEM_WE}, 64'd0);
        @(posedge CLK); #1;
        L_START = 1'b0;
        chk("ct_f_valid", {63'd0, F_VALID}, 64'd1);
        chk("ct_f_data", {32'd0, F_DATA}, 64'h5555_AAAA);
        @(negedge CLK);
        chk("ct_gnt_load", {63'd0, F_GNT}, 64'd0);
        chk("ct_busy", {63'd0, L_BUSY}, 64'd1);
        chk("ct_we", {63'd0, MEM_WE}, 64'd1);
        chk("ct_addr", {54'd0, MEM_ADDR}, 64'd200);
        @(posedge CLK); #1;
        F_REQ   = 1'b0;
        L_VALID = 1'b0;
        // Start while in DONE must be ignored
        L_START = 1'b1;
        L_BASE  = 10'd300;
        L_COUNT = 11'd3;
        @(negedge CLK);
        chk("ct_done", {63'd0, L_DONE}, 64'd1);
        @(posedge CLK); #1;
        L_START = 1'b0;
        @(negedge CLK);
        chk("ign_start_busy", {63'd0, L_BUSY}, 64'd0);
        chk("ign_start_done", done_n, 64'd1);
        @(posedge CLK); #1;

        // Reset in the middle of a 5-word burst, after 2 writes
        clear_log();
        L_BASE  = 10'd50;
        L_COUNT = 11'd5;
        L_VALID = 1'b1;
        L_DATA  = 32'hCAFE_0000;
        L_START = 1'b1;
        @(posedge CLK); #1;
        L_START = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        chk("ra_busy", {63'd0, L_BUSY}, 64'd0);
        chk("ra_ready", {63'd0, L_READY}, 64'd0);
        chk("ra_we", {63'd0, MEM_WE}, 64'd0);
        chk("ra_done", {63'd0, L_DONE}, 64'd0);
        chk("ra_f_data", {32'd0, F_DATA}, 64'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("ra_busy_after", {63'd0, L_BUSY}, 64'd0);
        L_VALID = 1'b0;
        chk("ra_nwr", q_addr.size(), 64'd2);
        chk("ra_addr0", {54'd0, q_addr[0]}, 64'd50);
        chk("ra_addr1", {54'd0, q_addr[1]}, 64'd51);
        chk("ra_done_n", done_n, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
